phrase_sequencer: RTL and testbench
===================================

// Module: phrase_sequencer
// PURPOSE
//   Upstream of the audio playback controller. Accepts a phrase of up to MAX_WORDS word codes,
//   for example the digits of a calculator result. For each code it reads that word's byte-address
//   range from an external clip ROM, then drives start_address/end_address/start to the playback
//   controller. It waits for each clip to finish and inserts a silent gap between clips.
// PARAMETERS
//   WORD_W       5      width of one word code (32-entry clip table)
//   MAX_WORDS    8      phrase buffer depth; count input width is $clog2(MAX_WORDS+1)
//   GAP_CYCLES   2500   idle clk cycles between consecutive clips (50 us at 50 MHz); 0 allowed
//   BUSY_TIMEOUT 16     max cycles to wait for play_finish to drop after play_start
// PORTS
//   clk          in   1                   50 MHz system clock
//   reset        in   1                   synchronous, active-high
//   req_valid    in   1                   phrase request present
//   req_ready    out  1                   1 only in IDLE; transfer = req_valid & req_ready
//   req_count    in   4                   number of words in the phrase, 0..MAX_WORDS
//   req_words    in   MAX_WORDS*WORD_W    word i is at [i*WORD_W +: WORD_W]; word 0 plays first
//   abort        in   1                   stop the phrase after the current clip
//   lut_addr     out  WORD_W              clip ROM index
//   lut_data     in   48                  {start[47:24], end[23:0]}; valid 1 cycle after lut_addr
//   start_address out 24                  byte address sent to the playback controller
//   end_address  out  24                  byte address sent to the playback controller
//   play_start   out  1                   one-cycle pulse; playback controller edge-detects it
//   play_finish  in   1                   playback controller idle flag (1 = idle)
//   busy         out  1                   1 in every state except IDLE
//   done         out  1                   one-cycle pulse when the phrase completes or abort drains
//   err          out  1                   sticky; set on a bad clip range or a busy timeout
// BEHAVIOUR
//   Reset: state=IDLE. req_ready=1. play_start=0, done=0, err=0, busy=0.
//     start_address=0, end_address=0, lut_addr=0, word index=0, all counters=0.
//   Reset mid-phrase returns to IDLE in 1 cycle and discards the buffer. It does not stop a clip
//     already playing in the playback controller.
//   All outputs are registered.
//   States: IDLE, FETCH, LUT_WAIT, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP, DRAIN.
//   IDLE: on transfer, latch req_words and cnt=min(req_count,MAX_WORDS), set idx=0, clear err.
//     cnt==0: done pulses on the next cycle; stay in IDLE.
//     cnt>0: go to FETCH.
//   FETCH: lut_addr <= word[idx]; go to LUT_WAIT.
//   LUT_WAIT (1 cycle): capture lut_data.
//     If end < start: set err, skip the word, go to the advance step.
//     Otherwise load start_address/end_address and go to LAUNCH.
//   LAUNCH: play_start=1 for exactly 1 cycle; the addresses stay stable until the next LAUNCH;
//     go to WAIT_BUSY.
//   WAIT_BUSY: wait for play_finish==0, then go to WAIT_DONE.
//     If play_finish has not dropped after BUSY_TIMEOUT cycles: set err, treat the clip as done,
//     go to the advance step.
//   WAIT_DONE: wait for play_finish==1, then go to the advance step.
//   Advance step: idx <= idx+1.
//     If idx+1 == cnt: done pulses for 1 cycle; go to IDLE. No GAP after the last word.
//     Otherwise: go to GAP; if GAP_CYCLES==0, go straight to FETCH.
//   GAP: count GAP_CYCLES cycles, then go to FETCH.
//   abort (sampled every cycle while busy):
//     in FETCH/LUT_WAIT/GAP: go to IDLE, done pulses.
//     in LAUNCH/WAIT_BUSY/WAIT_DONE: go to DRAIN.
//   DRAIN: wait for play_finish==1 with the same BUSY_TIMEOUT rule, then pulse done, go to IDLE.
//   abort in IDLE is ignored. A req_valid that arrives while busy is held off (req_ready=0),
//     never dropped.
//   If abort and the last clip's completion occur in the same cycle, the phrase completes
//     normally and done pulses once.
//   Widths: idx and cnt are $clog2(MAX_WORDS+1) bits; the gap counter is $clog2(GAP_CYCLES+1)
//     bits; no wraparound is possible.
// TESTING
//   1. Words {3,7}, count=2, ROM[3]=(0x100,0x1FF), ROM[7]=(0x400,0x47F), bench model
//      drops finish 2 cycles after start and raises it 20 cycles later -> two play_start pulses
//      with those addresses, exactly GAP_CYCLES idle cycles between them, done once, err=0.
//   2. count=0 -> done pulses on the cycle after the transfer, no play_start, busy stays 0.
//   3. ROM[5]=(0x200,0x100) inside the phrase {1,5,2} -> word 5 skipped, only 2 play_start
//      pulses, err=1 until the next request.
//   4. play_finish held at 1 after the launch -> err set after BUSY_TIMEOUT cycles, the
//      sequence proceeds to the next word.
//   5. abort during WAIT_DONE of word 0 of 3 -> no further play_start, done after finish
//      rises. abort during GAP -> IDLE and done on the next cycle.
//   6. reset asserted in WAIT_DONE -> the next cycle shows IDLE, req_ready=1, all outputs at
//      reset values; a new request is accepted normally.

Source files
------------

// File: rtl/phrase_sequencer.sv
// Sequences a phrase of word codes into ROM-addressed clips with a silent gap between them.
// All outputs registered, ROM read costs one cycle; req_ready is low (request held off) while busy.
`timescale 1ns/1ps
module phrase_sequencer #(
  parameter int WORD_W       = 5,
  parameter int MAX_WORDS    = 8,
  parameter int GAP_CYCLES   = 2500,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [$clog2(MAX_WORDS+1)-1:0] req_count,
  input  logic [MAX_WORDS*WORD_W-1:0]    req_words,
  input  logic                           abort,
  output logic [WORD_W-1:0]              lut_addr,
  input  logic [47:0]                    lut_data,
  output logic [23:0]                    start_address,
  output logic [23:0]                    end_address,
  output logic                           play_start,
  input  logic                           play_finish,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [TMO_W-1:0] TMO_LAST = (BUSY_TIMEOUT > 0) ? TMO_W'(BUSY_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LUT_WAIT, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_GAP, S_DRAIN
  } state_t;

  state_t                      state_q, state_d;
  logic [MAX_WORDS*WORD_W-1:0] words_q, words_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d, idx_q, idx_d;
  logic [GAP_W-1:0]            gap_q, gap_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic                        live_q, live_d;
  logic [WORD_W-1:0]           lut_addr_q, lut_addr_d;
  logic [23:0]                 start_address_q, start_address_d;
  logic [23:0]                 end_address_q, end_address_d;
  logic                        err_q, err_d, done_q, done_d;
  logic                        play_start_q, play_start_d;
  logic                        busy_q, busy_d, req_ready_q, req_ready_d;

  logic              adv, finish_now;
  logic [CNT_W-1:0]  req_cnt_clip;
  logic [WORD_W-1:0] cur_word;
  logic [23:0]       lut_start, lut_end;

  assign req_cnt_clip = (req_count > MAX_CNT) ? MAX_CNT : req_count;
  assign cur_word     = words_q[int'(idx_q) * WORD_W +: WORD_W];
  assign lut_start    = lut_data[47:24];
  assign lut_end      = lut_data[23:0];

  always_comb begin
    state_d         = state_q;
    words_d         = words_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    gap_d           = gap_q;
    tmo_d           = tmo_q;
    live_d          = live_q;
    lut_addr_d      = lut_addr_q;
    start_address_d = start_address_q;
    end_address_d   = end_address_q;
    err_d           = err_q;
    done_d          = 1'b0;
    adv             = 1'b0;
    finish_now      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          words_d = req_words;
          cnt_d   = req_cnt_clip;
          idx_d   = '0;
          err_d   = 1'b0;
          if (req_cnt_clip == '0) done_d = 1'b1;
          else                    state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) finish_now = 1'b1;
        else begin
          lut_addr_d = cur_word;
          state_d    = S_LUT_WAIT;
        end
      end
      S_LUT_WAIT: begin
        if (abort) finish_now = 1'b1;
        else if (lut_end < lut_start) begin
          err_d = 1'b1;
          adv   = 1'b1;
        end else begin
          start_address_d = lut_start;
          end_address_d   = lut_end;
          state_d         = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmo_d   = '0;
        live_d  = 1'b0;
        state_d = abort ? S_DRAIN : S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!play_finish) begin
          live_d  = 1'b1;
          state_d = abort ? S_DRAIN : S_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d = 1'b1;
          adv   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (abort) state_d = S_DRAIN;
        end
      end
      S_WAIT_DONE: begin
        if (play_finish) adv = 1'b1;
        else if (abort) begin
          live_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_GAP: begin
        if (abort) finish_now = 1'b1;
        else if (gap_q == GAP_LAST) state_d = S_FETCH;
        else gap_d = gap_q + 1'b1;
      end
      S_DRAIN: begin
        // live_q: the aborted clip has been seen playing, so only its end is awaited
        if (live_q) begin
          if (play_finish) finish_now = 1'b1;
        end else if (!play_finish) begin
          live_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          err_d      = 1'b1;
          finish_now = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      idx_d = idx_q + 1'b1;
      if (((idx_q + 1'b1) == cnt_q) || abort) finish_now = 1'b1;
      else if (GAP_CYCLES == 0) state_d = S_FETCH;
      else begin
        gap_d   = '0;
        state_d = S_GAP;
      end
    end
    if (finish_now) begin
      done_d  = 1'b1;
      state_d = S_IDLE;
    end

    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    play_start_d = (state_d == S_LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      words_q         <= '0;
      cnt_q           <= '0;
      idx_q           <= '0;
      gap_q           <= '0;
      tmo_q           <= '0;
      live_q          <= 1'b0;
      lut_addr_q      <= '0;
      start_address_q <= '0;
      end_address_q   <= '0;
      err_q           <= 1'b0;
      done_q          <= 1'b0;
      play_start_q    <= 1'b0;
      busy_q          <= 1'b0;
      req_ready_q     <= 1'b1;
    end else begin
      state_q         <= state_d;
      words_q         <= words_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      gap_q           <= gap_d;
      tmo_q           <= tmo_d;
      live_q          <= live_d;
      lut_addr_q      <= lut_addr_d;
      start_address_q <= start_address_d;
      end_address_q   <= end_address_d;
      err_q           <= err_d;
      done_q          <= done_d;
      play_start_q    <= play_start_d;
      busy_q          <= busy_d;
      req_ready_q     <= req_ready_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign lut_addr      = lut_addr_q;
  assign start_address = start_address_q;
  assign end_address   = end_address_q;
  assign play_start    = play_start_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_phrase_sequencer.sv
// Bench for phrase_sequencer: directed scenarios plus random phrases against a phrase-level model.
`timescale 1ns/1ps
module tb_phrase_sequencer;
  localparam int WORD_W    = 5;
  localparam int MAX_WORDS = 8;
  localparam int GAP       = 12;
  localparam int TMO       = 16;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int BOUND     = 3000;

  logic clk = 1'b0;
  logic reset, req_valid, req_ready, abort, play_start, play_finish, busy, done, err;
  logic [CNT_W-1:0]            req_count;
  logic [MAX_WORDS*WORD_W-1:0] req_words;
  logic [WORD_W-1:0]           lut_addr;
  logic [47:0]                 lut_data;
  logic [23:0]                 start_address, end_address;
  logic [47:0]                 rom [32];

  always #10 clk = ~clk;
  assign lut_data = rom[lut_addr];

  phrase_sequencer #(.WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_count(req_count), .req_words(req_words), .abort(abort), .lut_addr(lut_addr),
    .lut_data(lut_data), .start_address(start_address), .end_address(end_address),
    .play_start(play_start), .play_finish(play_finish), .busy(busy), .done(done), .err(err)
  );

  int total = 0, bad = 0;
  int cyc = 0, n_done = 0, done_cyc = 0, busy_cycles = 0, ps_long = 0;
  int fin_drop = 2, fin_len = 20, stuck_at = -1, pc = 0;
  logic ps_prev = 1'b0;
  logic [47:0] l_addr [$];
  int          l_cyc [$];
  int          rise_cyc [$];

  // Monitor plus playback-controller model: samples on the falling edge, then updates play_finish.
  initial begin
    play_finish = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (play_start) begin
        l_addr.push_back({start_address, end_address});
        l_cyc.push_back(cyc);
        if (ps_prev) ps_long++;
      end
      ps_prev = play_start;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (busy) busy_cycles++;
      if (pc != 0) pc++;
      if (play_start && (l_addr.size() - 1 != stuck_at)) pc = 1;
      if (pc == 1 + fin_drop) play_finish = 1'b0;
      if (pc == 1 + fin_drop + fin_len) begin
        play_finish = 1'b1;
        rise_cyc.push_back(cyc);
        pc = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [MAX_WORDS*WORD_W-1:0] words, input int count, output int xfer_cyc);
    int i;
    i = 0;
    while (!req_ready && i < BOUND) begin step(1); i++; end
    check("req_ready_before_send", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_words = words;
    req_count = CNT_W'(count);
    xfer_cyc  = cyc;
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_launches(input int n, input string tag);
    int i;
    i = 0;
    while (l_addr.size() < n && i < BOUND) begin step(1); i++; end
    check({tag, "_launch_wait"}, 64'(l_addr.size() >= n), 64'd1);
  endtask

  task automatic wait_rises(input int n, input string tag);
    int i;
    i = 0;
    while (rise_cyc.size() < n && i < BOUND) begin step(1); i++; end
    check({tag, "_finish_wait"}, 64'(rise_cyc.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input int n, input string tag);
    int i;
    i = 0;
    while (n_done < n && i < BOUND) begin step(1); i++; end
    check({tag, "_done_wait"}, 64'(n_done >= n), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"},  64'(req_ready),     64'd1);
    check({tag, "_busy"},       64'(busy),          64'd0);
    check({tag, "_done"},       64'(done),          64'd0);
    check({tag, "_err"},        64'(err),           64'd0);
    check({tag, "_play_start"}, 64'(play_start),    64'd0);
    check({tag, "_start_addr"}, 64'(start_address), 64'd0);
    check({tag, "_end_addr"},   64'(end_address),   64'd0);
    check({tag, "_lut_addr"},   64'(lut_addr),      64'd0);
  endtask

  function automatic logic [MAX_WORDS*WORD_W-1:0] pack3(input int w0, input int w1, input int w2);
    logic [MAX_WORDS*WORD_W-1:0] v;
    v = '0;
    v[0 +: WORD_W]        = WORD_W'(w0);
    v[WORD_W +: WORD_W]   = WORD_W'(w1);
    v[2*WORD_W +: WORD_W] = WORD_W'(w2);
    return v;
  endfunction

  initial begin
    int xc, bl, bd, br, bb, a, cnt, eff;
    int unsigned s, e;
    logic exp_err;
    logic [47:0] ent;
    logic [47:0] exp_q [$];
    logic [MAX_WORDS*WORD_W-1:0] w;

    reset = 1'b1; req_valid = 1'b0; abort = 1'b0; req_count = '0; req_words = '0;
    for (int i = 0; i < 32; i++) rom[i] = '0;
    rom[1] = {24'h000010, 24'h000020};
    rom[2] = {24'h000030, 24'h00003F};
    rom[3] = {24'h000100, 24'h0001FF};
    rom[5] = {24'h000200, 24'h000100};
    rom[7] = {24'h000400, 24'h00047F};
    step(3);
    check_idle("reset");
    reset = 1'b0;
    step(1);

    // 1: two-word phrase, addresses, gap spacing, single done
    bl = l_addr.size(); bd = n_done; br = rise_cyc.size();
    send(pack3(3, 7, 0), 2, xc);
    wait_done(bd + 1, "t1");
    step(4);
    check("t1_launches", 64'(l_addr.size() - bl), 64'd2);
    if (l_addr.size() >= bl + 2 && rise_cyc.size() >= br + 2) begin
      check("t1_clip0", 64'(l_addr[bl]),     {16'd0, 24'h000100, 24'h0001FF});
      check("t1_clip1", 64'(l_addr[bl + 1]), {16'd0, 24'h000400, 24'h00047F});
      // GAP idle cycles, then FETCH, LUT_WAIT and the launch cycle
      check("t1_gap_spacing", 64'(l_cyc[bl + 1] - rise_cyc[br]), 64'(GAP + 3));
      check("t1_done_after_last", 64'(done_cyc - rise_cyc[br + 1]), 64'd1);
    end
    check("t1_done_count", 64'(n_done - bd), 64'd1);
    check("t1_err", 64'(err), 64'd0);

    // 2: empty phrase
    bl = l_addr.size(); bd = n_done; bb = busy_cycles;
    send('0, 0, xc);
    step(3);
    check("t2_done_count", 64'(n_done - bd), 64'd1);
    check("t2_done_cycle", 64'(done_cyc - xc), 64'd1);
    check("t2_launches", 64'(l_addr.size() - bl), 64'd0);
    check("t2_busy_cycles", 64'(busy_cycles - bb), 64'd0);

    // 3: bad range in the middle word is skipped
    bl = l_addr.size(); bd = n_done;
    send(pack3(1, 5, 2), 3, xc);
    wait_done(bd + 1, "t3");
    step(3);
    check("t3_launches", 64'(l_addr.size() - bl), 64'd2);
    if (l_addr.size() >= bl + 2) begin
      check("t3_clip0", 64'(l_addr[bl]),     {16'd0, 24'h000010, 24'h000020});
      check("t3_clip1", 64'(l_addr[bl + 1]), {16'd0, 24'h000030, 24'h00003F});
    end
    check("t3_err", 64'(err), 64'd1);
    step(5);
    check("t3_err_sticky", 64'(err), 64'd1);

    // 4: controller never goes busy on the first clip
    bl = l_addr.size(); bd = n_done;
    stuck_at = bl;
    send(pack3(3, 7, 0), 2, xc);
    check("t4_err_cleared", 64'(err), 64'd0);
    wait_launches(bl + 1, "t4");
    if (l_addr.size() >= bl + 1) begin
      step(l_cyc[bl] + TMO - cyc);
      check("t4_err_before_timeout", 64'(err), 64'd0);
      step(2);
      check("t4_err_after_timeout", 64'(err), 64'd1);
    end
    wait_done(bd + 1, "t4");
    step(3);
    stuck_at = -1;
    check("t4_launches", 64'(l_addr.size() - bl), 64'd2);
    if (l_addr.size() >= bl + 2)
      check("t4_clip1", 64'(l_addr[bl + 1]), {16'd0, 24'h000400, 24'h00047F});
    check("t4_done_count", 64'(n_done - bd), 64'd1);

    // 5a: abort while the first of three clips plays
    bl = l_addr.size(); bd = n_done; br = rise_cyc.size();
    send(pack3(3, 7, 3), 3, xc);
    wait_launches(bl + 1, "t5a");
    if (l_addr.size() >= bl + 1) step(l_cyc[bl] + 5 - cyc);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    wait_done(bd + 1, "t5a");
    if (rise_cyc.size() > br)
      check("t5a_done_after_finish", 64'(done_cyc - rise_cyc[br]), 64'd1);
    step(GAP + 10);
    check("t5a_launches", 64'(l_addr.size() - bl), 64'd1);
    check("t5a_done_count", 64'(n_done - bd), 64'd1);

    // 5b: abort in the gap
    bl = l_addr.size(); bd = n_done; br = rise_cyc.size();
    send(pack3(3, 7, 0), 2, xc);
    wait_rises(br + 1, "t5b");
    step(2);
    abort = 1'b1;
    a = cyc;
    step(1);
    abort = 1'b0;
    wait_done(bd + 1, "t5b");
    check("t5b_done_cycle", 64'(done_cyc - a), 64'd1);
    step(GAP + 10);
    check("t5b_launches", 64'(l_addr.size() - bl), 64'd1);

    // 6: reset while a clip plays, then a normal request
    bl = l_addr.size();
    send(pack3(3, 7, 0), 2, xc);
    wait_launches(bl + 1, "t6");
    step(5);
    reset = 1'b1;
    step(1);
    check_idle("t6_reset");
    reset = 1'b0;
    a = 0;
    while (!play_finish && a < BOUND) begin step(1); a++; end
    bl = l_addr.size(); bd = n_done;
    send(pack3(7, 0, 0), 1, xc);
    wait_done(bd + 1, "t6");
    step(3);
    check("t6_launches", 64'(l_addr.size() - bl), 64'd1);
    if (l_addr.size() >= bl + 1)
      check("t6_clip0", 64'(l_addr[bl]), {16'd0, 24'h000400, 24'h00047F});
    check("t6_err", 64'(err), 64'd0);

    // Random phrases: expected clips are the in-range ROM entries of the first min(count,8) words
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 32; i++) begin
        s = $urandom_range(1, 32'hFFF000);
        if ($urandom_range(0, 4) == 0) e = s - $urandom_range(1, s);
        else                           e = s + $urandom_range(0, 32'hFFF);
        rom[i] = {s[23:0], e[23:0]};
      end
      w = '0;
      for (int i = 0; i < MAX_WORDS; i++) w[i*WORD_W +: WORD_W] = WORD_W'($urandom_range(0, 31));
      cnt = $urandom_range(0, 10);
      eff = (cnt > MAX_WORDS) ? MAX_WORDS : cnt;
      exp_err = 1'b0;
      exp_q.delete();
      for (int i = 0; i < eff; i++) begin
        ent = rom[w[i*WORD_W +: WORD_W]];
        if (ent[23:0] < ent[47:24]) exp_err = 1'b1;
        else exp_q.push_back(ent);
      end
      fin_drop = $urandom_range(1, 4);
      fin_len  = $urandom_range(1, 10);
      bl = l_addr.size(); bd = n_done; bb = busy_cycles;
      if (exp_q.size() > 0 && $urandom_range(0, 3) == 0) begin
        stuck_at = bl;
        exp_err  = 1'b1;
      end
      send(w, cnt, xc);
      wait_done(bd + 1, "rnd");
      step(3);
      stuck_at = -1;
      check("rnd_launches", 64'(l_addr.size() - bl), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && bl + i < l_addr.size(); i++)
        check("rnd_clip", 64'(l_addr[bl + i]), 64'(exp_q[i]));
      check("rnd_err", 64'(err), 64'(exp_err));
      check("rnd_done_count", 64'(n_done - bd), 64'd1);
      if (eff == 0) check("rnd_empty_busy", 64'(busy_cycles - bb), 64'd0);
    end

    check("play_start_width", 64'(ps_long), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
